// File: rtl/onehot_read_seq.sv
// Purpose : registered one-hot IDLE/READ/DLY/DONE read sequencer for a slow wait-state memory.
// Latency : go sampled at edge N -> READ@N, DLY@N+1, DONE@N+2, IDLE@N+3; each ws retry adds 2 cycles.
// Backpr. : no queueing; go is only honoured in IDLE. mem_ws stalls by re-strobing the read, up to TIMEOUT reads.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   go_i         start request (sampled in IDLE only)
//   addr_i       read address, latched when go is accepted
//   mem_rd_o     read strobe, high for each READ cycle
//   mem_addr_o   latched read address
//   mem_ws_i     memory wait state (sampled in DLY only)
//   mem_rdata_i  memory read data (captured in DLY when mem_ws_i==0)
//   rdata_o      captured read data, holds between reads
//   done_o       one-cycle completion pulse (DONE state)
//   err_o        timeout flag, sticky until the next accepted go
//   busy_o       high whenever the sequencer is not IDLE
//   state_o      one-hot state: IDLE=0001 READ=0010 DLY=0100 DONE=1000
module onehot_read_seq #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          go_i,
  input  logic [AW-1:0] addr_i,
  output logic          mem_rd_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic          mem_ws_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          done_o,
  output logic          err_o,
  output logic          busy_o,
  output logic [3:0]    state_o
);

  // Retry counter must be able to hold TIMEOUT-1.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] RETRY_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_READ = 4'b0010,
    S_DLY  = 4'b0100,
    S_DONE = 4'b1000
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [CW-1:0]   retry_q, retry_d;
  logic            err_q, err_d;
  logic            mem_rd_q, done_q, busy_q;

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    rdata_d    = rdata_q;
    retry_d    = retry_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (go_i) begin
          state_d    = S_READ;
          mem_addr_d = addr_i;
          err_d      = 1'b0;
          retry_d    = '0;
        end
      end

      S_READ: begin
        state_d = S_DLY;
      end

      S_DLY: begin
        if (!mem_ws_i) begin
          state_d = S_DONE;
          rdata_d = mem_rdata_i;
        end else if (retry_q == RETRY_MAX) begin
          // Out of retries: finish without touching rdata so the previous
          // good value is still visible to the requester.
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = S_READ;
          retry_d = retry_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      // Corrupted (non one-hot) encoding: recover to IDLE, keep rdata/err.
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register and registered outputs. The strobe/pulse/busy flags are
  // decoded from the next state so they line up exactly with state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      mem_addr_q <= '0;
      rdata_q    <= '0;
      retry_q    <= '0;
      err_q      <= 1'b0;
      mem_rd_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      rdata_q    <= rdata_d;
      retry_q    <= retry_d;
      err_q      <= err_d;
      mem_rd_q   <= (state_d == S_READ);
      done_q     <= (state_d == S_DONE);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign state_o    = state_q;
  assign mem_rd_o   = mem_rd_q;
  assign mem_addr_o = mem_addr_q;
  assign rdata_o    = rdata_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_onehot_read_seq.sv
module tb_onehot_read_seq;

  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_READ = 4'b0010;
  localparam logic [3:0] ST_DLY  = 4'b0100;
  localparam logic [3:0] ST_DONE = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       go;
  logic [7:0] addr;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic       mem_ws;
  logic [7:0] mem_rdata;
  logic [7:0] rdata;
  logic       done;
  logic       err;
  logic       busy;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  onehot_read_seq #(.AW(8), .DW(8), .TIMEOUT(15)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .go_i        (go),
    .addr_i      (addr),
    .mem_rd_o    (mem_rd),
    .mem_addr_o  (mem_addr),
    .mem_ws_i    (mem_ws),
    .mem_rdata_i (mem_rdata),
    .rdata_o     (rdata),
    .done_o      (done),
    .err_o       (err),
    .busy_o      (busy),
    .state_o     (state)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; go = 1'b1; addr = 8'hFF; mem_ws = 1'b0; mem_rdata = 8'hFF;
    repeat (3) tick();
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %b exp %b", state, ST_IDLE); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got %b exp 0", mem_rd); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr got %h exp 00", mem_addr); end
    go = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL post_reset_idle got %b exp %b", state, ST_IDLE); end
  endtask

  task automatic test_zero_wait();
    go = 1'b1; addr = 8'h3C; mem_ws = 1'b0; mem_rdata = 8'hA5;
    tick();
    go = 1'b0; addr = 8'h00;
    checks++; if (state !== ST_READ) begin errors++; $display("FAIL zw_read_state got %b exp %b", state, ST_READ); end
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL zw_mem_rd got %b exp 1", mem_rd); end
    checks++; if (mem_addr !== 8'h3C) begin errors++; $display("FAIL zw_mem_addr got %h exp 3c", mem_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zw_busy got %b exp 1", busy); end
    tick();
    checks++; if (state !== ST_DLY) begin errors++; $display("FAIL zw_dly_state got %b exp %b", state, ST_DLY); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL zw_mem_rd_drop got %b exp 0", mem_rd); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zw_done got %b exp 1", done); end
    checks++; if (state !== ST_DONE) begin errors++; $display("FAIL zw_done_state got %b exp %b", state, ST_DONE); end
    checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL zw_rdata got %h exp a5", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL zw_err got %b exp 0", err); end
    tick();
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL zw_idle got %b exp %b", state, ST_IDLE); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zw_idle_flags got done=%b busy=%b exp 0 0", done, busy); end
  endtask

  task automatic test_two_ws();
    logic [3:0] exp_st [7];
    int rd_cnt;
    exp_st = '{ST_READ, ST_DLY, ST_READ, ST_DLY, ST_READ, ST_DLY, ST_DONE};
    rd_cnt = 0;
    go = 1'b1; addr = 8'h81; mem_ws = 1'b1; mem_rdata = 8'hFF;
    for (int k = 0; k < 7; k++) begin
      tick();
      go = 1'b0;
      if (mem_rd === 1'b1) rd_cnt++;
      checks++; if (state !== exp_st[k]) begin errors++; $display("FAIL ws2_state_c%0d got %b exp %b", k, state, exp_st[k]); end
      // The DLY sample at edge N+6 is the first with ws low.
      mem_ws    = (k + 1 == 6) ? 1'b0 : 1'b1;
      mem_rdata = (k + 1 == 6) ? 8'h5A : 8'hFF;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ws2_done got %b exp 1", done); end
    checks++; if (rd_cnt != 3) begin errors++; $display("FAIL ws2_rd_pulses got %0d exp 3", rd_cnt); end
    checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL ws2_rdata got %h exp 5a", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ws2_err got %b exp 0", err); end
    tick();
  endtask

  task automatic test_timeout();
    int rd_cnt;
    int done_at;
    rd_cnt = 0;
    done_at = -1;
    go = 1'b1; addr = 8'h77; mem_ws = 1'b1; mem_rdata = 8'hEE;
    for (int k = 0; k < 60 && done_at < 0; k++) begin
      tick();
      go = 1'b0;
      if (mem_rd === 1'b1) rd_cnt++;
      if (done === 1'b1) done_at = k;
    end
    checks++; if (done_at != 30) begin errors++; $display("FAIL to_done_cycle got %0d exp 30", done_at); end
    checks++; if (rd_cnt != 15) begin errors++; $display("FAIL to_rd_pulses got %0d exp 15", rd_cnt); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err_at_done got %b exp 1", err); end
    checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL to_rdata_kept got %h exp 5a", rdata); end
    tick();
    checks++; if (state !== ST_IDLE || err !== 1'b1) begin errors++; $display("FAIL to_err_sticky got state=%b err=%b exp 0001 1", state, err); end
    mem_ws = 1'b0; mem_rdata = 8'h11; go = 1'b1; addr = 8'h12;
    tick();
    go = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_cleared got %b exp 0", err); end
    repeat (3) tick();
    checks++; if (rdata !== 8'h11 || err !== 1'b0) begin errors++; $display("FAIL to_recover got rdata=%h err=%b exp 11 0", rdata, err); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_st [4];
    logic [7:0] exp_addr;
    logic [7:0] exp_rdata;
    exp_st = '{ST_READ, ST_DLY, ST_DONE, ST_IDLE};
    mem_ws = 1'b0;
    for (int k = 0; k < 12; k++) begin
      go = 1'b1;
      addr = 8'(8'h10 + k);
      mem_rdata = 8'(8'hC0 + k);
      tick();
      exp_addr = 8'(8'h10 + (k / 4) * 4);
      checks++; if (state !== exp_st[k % 4]) begin errors++; $display("FAIL b2b_state_c%0d got %b exp %b", k, state, exp_st[k % 4]); end
      checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL b2b_addr_c%0d got %h exp %h", k, mem_addr, exp_addr); end
      if (k % 4 == 2) begin
        exp_rdata = 8'(8'hC0 + k);
        checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL b2b_rdata_c%0d got %h exp %h", k, rdata, exp_rdata); end
      end
    end
    go = 1'b0;
  endtask

  task automatic test_async_reset();
    // Reset mid-READ: strobe must drop without a clock edge.
    go = 1'b1; addr = 8'h24; mem_ws = 1'b1; mem_rdata = 8'h33;
    tick();
    go = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checks++; if (state !== ST_IDLE || mem_rd !== 1'b0) begin errors++; $display("FAIL ar_read got state=%b mem_rd=%b exp 0001 0", state, mem_rd); end
    @(posedge clk); #1 rst_n = 1'b1;
    // Reset in DLY.
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    checks++; if (state !== ST_DLY) begin errors++; $display("FAIL ar_pre_dly got %b exp %b", state, ST_DLY); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL ar_dly_state got %b exp %b", state, ST_IDLE); end
    checks++; if (mem_rd !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ar_dly_flags got mem_rd=%b busy=%b exp 0 0", mem_rd, busy); end
    checks++; if (rdata !== 8'h00 || mem_addr !== 8'h00) begin errors++; $display("FAIL ar_dly_regs got rdata=%h addr=%h exp 00 00", rdata, mem_addr); end
    @(posedge clk); #1 rst_n = 1'b1;
    go = 1'b1; addr = 8'h42; mem_ws = 1'b0; mem_rdata = 8'h99;
    tick();
    go = 1'b0;
    checks++; if (state !== ST_READ || mem_rd !== 1'b1 || mem_addr !== 8'h42) begin errors++; $display("FAIL ar_restart got state=%b mem_rd=%b addr=%h exp 0010 1 42", state, mem_rd, mem_addr); end
    repeat (2) tick();
    checks++; if (done !== 1'b1 || rdata !== 8'h99) begin errors++; $display("FAIL ar_restart_done got done=%b rdata=%h exp 1 99", done, rdata); end
    tick();
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL ar_final_idle got %b exp %b", state, ST_IDLE); end
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; addr = '0; mem_ws = 1'b0; mem_rdata = '0;
    test_reset();
    test_zero_wait();
    test_two_ws();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
